// File: rtl/sodor_feeder_pkg.sv
// Shared constants and state type for the Sodor instruction-memory feeder.
package sodor_feeder_pkg;

    localparam logic [31:0] NOP_INST      = 32'h00000013;
    localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLED,
        ST_TARGET,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/sodor_feeder_resp_pipe.sv
// Fixed-latency response pipe: RESP_LAT-deep shift register of
// {valid, addr, data, is_target}. The head entry drives the response port.
// o_empty means nothing is queued behind the head, so the pipe holds no
// valid entry after this cycle unless a new one is pushed.
module sodor_feeder_resp_pipe
    import sodor_feeder_pkg::*;
#(
    parameter int RESP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push_valid,
    input  logic [31:0] i_push_addr,
    input  logic [31:0] i_push_data,
    input  logic        i_push_target,
    output logic        o_valid,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic        o_target,
    output logic        o_empty
);

    logic [RESP_LAT-1:0] r_valid;
    logic [RESP_LAT-1:0] r_target;
    logic [31:0]         r_addr [RESP_LAT];
    logic [31:0]         r_data [RESP_LAT];

    // Shift every entry one stage toward the head each cycle; reset drops all in-flight entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RESP_LAT; i++) begin
                r_valid[i]  <= 1'b0;
                r_target[i] <= 1'b0;
                r_addr[i]   <= 32'h0;
                r_data[i]   <= NOP_INST;
            end
        end else begin
            r_valid[0]  <= i_push_valid;
            r_target[0] <= i_push_valid & i_push_target;
            r_addr[0]   <= i_push_addr;
            r_data[0]   <= i_push_data;
            for (int i = 1; i < RESP_LAT; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_target[i] <= r_target[i-1];
                r_addr[i]   <= r_addr[i-1];
                r_data[i]   <= r_data[i-1];
            end
        end
    end

    assign o_valid  = r_valid[RESP_LAT-1];
    assign o_target = r_valid[RESP_LAT-1] & r_target[RESP_LAT-1];
    assign o_addr   = r_addr[RESP_LAT-1];
    assign o_data   = r_data[RESP_LAT-1];

    generate
        if (RESP_LAT == 1) begin : g_single
            assign o_empty = 1'b1;
        end else begin : g_multi
            assign o_empty = ~|r_valid[RESP_LAT-2:0];
        end
    endgenerate

endmodule

// File: rtl/sodor_imem_feeder.sv
// Instruction-memory feeder for the Sodor 5-stage model: answers fetches with
// a NOP sled, one instruction under test, then a NOP drain.
// Optional feature: define SODOR_FEEDER_ITYPE_FILTER_EN to reject loads that
// are not OP-IMM or are the canonical NOP; rejected loads go straight to DONE.
module sodor_imem_feeder
    import sodor_feeder_pkg::*;
#(
    parameter int NOP_SLED = 4,
    parameter int DRAIN    = 5,
    parameter int RESP_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_inst,
    output logic        load_ready,
    input  logic        imem_req_valid,
    input  logic [31:0] imem_req_addr,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_bits_data,
    output logic [31:0] imem_resp_addr,
    output logic        target_issued,
    output logic        busy,
    output logic        done,
    output logic        filtered
);

    feeder_state_t r_state;
    logic [7:0]    r_sledCnt;
    logic [7:0]    r_drainCnt;
    logic [31:0]   r_inst;
    logic          r_done;
    logic          r_filtered;

    logic          w_reject;
    logic          w_pushTarget;
    logic [31:0]   w_pushData;
    logic          w_pipeEmpty;

`ifdef SODOR_FEEDER_ITYPE_FILTER_EN
    assign w_reject = (load_inst[6:0] != OPCODE_OP_IMM) || (load_inst == NOP_INST);
`else
    assign w_reject = 1'b0;
`endif

    assign load_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy         = !load_ready;
    assign done         = r_done;
    assign filtered     = r_filtered;
    assign w_pushTarget = (r_state == ST_TARGET);
    assign w_pushData   = w_pushTarget ? r_inst : NOP_INST;

    // Sequence controller: accepted loads start a run, accepted requests advance the sled/target/drain counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sledCnt  <= 8'd0;
            r_drainCnt <= 8'd0;
            r_inst     <= NOP_INST;
            r_done     <= 1'b0;
            r_filtered <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (r_state == ST_DONE) begin
                        r_done <= 1'b1;
                    end
                    if (load_valid) begin
                        r_inst     <= load_inst;
                        r_sledCnt  <= 8'(NOP_SLED);
                        r_done     <= 1'b0;
                        r_filtered <= 1'b0;
                        if (w_reject) begin
                            r_filtered <= 1'b1;
                            r_state    <= ST_DONE;
                        end else if (NOP_SLED == 0) begin
                            r_state <= ST_TARGET;
                        end else begin
                            r_state <= ST_SLED;
                        end
                    end
                end
                ST_SLED: begin
                    if (imem_req_valid) begin
                        if (r_sledCnt != 8'd0) begin
                            r_sledCnt <= r_sledCnt - 8'd1;
                        end
                        if (r_sledCnt <= 8'd1) begin
                            r_state <= ST_TARGET;
                        end
                    end
                end
                ST_TARGET: begin
                    if (imem_req_valid) begin
                        r_drainCnt <= 8'(DRAIN);
                        r_state    <= (DRAIN == 0) ? ST_FLUSH : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (imem_req_valid) begin
                        if (r_drainCnt != 8'd0) begin
                            r_drainCnt <= r_drainCnt - 8'd1;
                        end
                        if (r_drainCnt <= 8'd1) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_pipeEmpty && !imem_req_valid) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sodor_feeder_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_respPipe (
        .clk           (clk),
        .reset         (reset),
        .i_push_valid  (imem_req_valid),
        .i_push_addr   (imem_req_addr),
        .i_push_data   (w_pushData),
        .i_push_target (w_pushTarget),
        .o_valid       (imem_resp_valid),
        .o_addr        (imem_resp_addr),
        .o_data        (imem_resp_bits_data),
        .o_target      (target_issued),
        .o_empty       (w_pipeEmpty)
    );

endmodule

// File: doc/sodor_imem_feeder.md
# sodor_imem_feeder

Instruction-memory stimulus block upstream of the Sodor 5-stage micro-op model. It answers the model's fetch requests with an instruction stream of a NOP sled, then exactly one instruction under test, then a NOP drain. It produces the `fe_in_io_imem_resp_bits_data` stream the model consumes and reports when the target has been issued and the stream is finished.

## Interface
- `NOP_SLED`, default 4: NOPs returned before the target (0..255).
- `DRAIN`, default 5: NOPs returned after the target (0..255). The default matches the model's end state.
- `RESP_LAT`, default 1: request-to-response latency in cycles (1..4).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `load_valid`, in, 1: target instruction offered.
- `load_inst`, in, 32: instruction under test.
- `load_ready`, out, 1: high in IDLE and DONE.
- `imem_req_valid`, in, 1: fetch request. Always accepted; there is no back-pressure.
- `imem_req_addr`, in, 32: fetch PC.
- `imem_resp_valid`, out, 1: response valid.
- `imem_resp_bits_data`, out, 32: returned instruction.
- `imem_resp_addr`, out, 32: echo of the request address.
- `target_issued`, out, 1: one-cycle pulse, coincident with the target on the response port.
- `busy`, out, 1: state is not IDLE and not DONE.
- `done`, out, 1: sticky completion flag.
- `filtered`, out, 1: target rejected (see Configuration).

## Operation
- States: IDLE, SLED, TARGET, DRAIN, FLUSH, DONE.
- Data is selected when a request is accepted, then carried through the response pipe.
- IDLE:
  - Requests are answered with NOP (32'h00000013). Nothing is counted.
  - A `load_valid` && `load_ready` handshake latches `load_inst` and loads `sled_cnt` = NOP_SLED.
  - Next state is SLED, or TARGET if NOP_SLED = 0.
- SLED: each accepted request returns NOP and decrements `sled_cnt`. On the request that takes `sled_cnt` from 1 to 0, go to TARGET.
- TARGET: the next accepted request returns the latched instruction. Load `drain_cnt` = DRAIN. Go to DRAIN, or FLUSH if DRAIN = 0.
- DRAIN: each accepted request returns NOP and decrements `drain_cnt`. At 0, go to FLUSH.
- FLUSH: requests return NOP. When the response pipe is empty, go to DONE.
- DONE:
  - `done` = 1. Requests return NOP.
  - `load_ready` = 1. A new load clears `done` and `filtered` and restarts as from IDLE.
- `load_valid` while `load_ready` = 0 is ignored; no state changes.
- A simultaneous request and load in IDLE/DONE: the request is served with IDLE/DONE semantics (NOP, uncounted). The load takes effect for the following requests.
- Counters are 8-bit and never wrap: decrements happen only while the counter is non-zero.
- `imem_resp_addr` always equals the `imem_req_addr` of the same request.

## Timing
- A request accepted in cycle t appears on the response port in cycle t+RESP_LAT, with `imem_resp_valid` = 1 for exactly one cycle.
- Back-to-back requests produce back-to-back responses.
- `target_issued` is high in the same cycle the target is on `imem_resp_bits_data`.
- FLUSH→DONE happens in the cycle after the last valid response. `done` is registered and rises the following cycle.
- Reset values:
  - `imem_resp_valid` = 0, `imem_resp_bits_data` = 32'h00000013, `imem_resp_addr` = 0.
  - `target_issued` = 0, `busy` = 0, `done` = 0, `filtered` = 0, `load_ready` = 1.
  - State is IDLE; counters and the response pipe are cleared.
- Reset mid-operation drops all in-flight responses. No response is valid in the cycle after reset is sampled.

## Configuration
- `SODOR_FEEDER_ITYPE_FILTER_EN` defined:
  - At load, an instruction is rejected if `load_inst[6:0]` != 7'b0010011 or `load_inst` == 32'h00000013.
  - On rejection the block goes straight to DONE with `filtered` = 1. No target is emitted and requests continue to get NOP.
- Not defined: every instruction passes through, and `filtered` is tied to 0.

## Structure
- `sodor_feeder_pkg` holds:
  - `NOP_INST` = 32'h00000013 and `OPCODE_OP_IMM` = 7'b0010011.
  - The state enum `feeder_state_t`.
- Sub-module `sodor_feeder_resp_pipe`: a RESP_LAT-deep shift register of {valid, addr, data, is_target}. It outputs the head entry and an `empty` flag. Its reset clears all valid bits.

## Test plan
- Defaults, load 32'h00708293 (addi x5,x1,7), continuous requests at PC 0,4,8… → responses: 4×NOP at PCs 0..12, target at PC 16 with `target_issued`, then 5×NOP; `done` rises 2 cycles after the last response.
- NOP_SLED = 0, DRAIN = 0, RESP_LAT = 3, a single request at PC 0x40 → target returned at PC 0x40 exactly 3 cycles later; `done` follows.
- Requests with gaps (valid 1,0,0,1…) during SLED → only accepted requests decrement the counter; the target still lands on the 5th accepted request.
- Assert reset while the target is in flight (RESP_LAT = 2) → no `imem_resp_valid` and no `target_issued` after reset; all outputs at their reset values.
- Macro on, load 32'h00000033 (add) → `filtered` = 1 and `done` = 1 within 2 cycles; all responses are NOP. Macro off, same load → target emitted normally and `filtered` stays 0.
- In DONE, load 32'h00A00093 → `done` and `filtered` clear and the sequence replays; a second `load_valid` during SLED is ignored.
